// File: rtl/clock_demux_2_if.sv
// Handshake bundle for clock_demux_2: one routed input stream and two buffered output slots.
// The master side drives the input word and consumer readies; the slave side is the demux.
interface clock_demux_2_if #(
  parameter int N = 32
);
  logic [N-1:0] D;
  logic         Ctrl;
  logic         In_valid;
  logic         In_ready;
  logic [N-1:0] A;
  logic         A_valid;
  logic         A_ready;
  logic [N-1:0] B;
  logic         B_valid;
  logic         B_ready;
  logic [7:0]   A_cnt;
  logic [7:0]   B_cnt;

  modport master (
    output D, Ctrl, In_valid, A_ready, B_ready,
    input  In_ready, A, A_valid, B, B_valid, A_cnt, B_cnt
  );

  modport slave (
    input  D, Ctrl, In_valid, A_ready, B_ready,
    output In_ready, A, A_valid, B, B_valid, A_cnt, B_cnt
  );
endinterface

// File: rtl/clock_demux_2.sv
// Routes each accepted input word into one of two single-entry output slots (A or B) chosen by Ctrl,
// with per-slot valid/ready handshakes and modulo-256 delivery counters.
module clock_demux_2 #(
  parameter int N = 32
) (
  input logic           clk,
  input logic           rst_n,
  clock_demux_2_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

  slot_state_t  a_state, b_state;
  logic [N-1:0] a_data, b_data;
  logic [7:0]   a_cnt, b_cnt;
  logic         a_free, b_free, in_ready;
  logic         accept_a, accept_b, deliver_a, deliver_b;

  // A slot can take a word if it is empty or its current word leaves this same cycle.
  assign a_free    = (a_state == EMPTY) | bus.A_ready;
  assign b_free    = (b_state == EMPTY) | bus.B_ready;
  assign in_ready  = rst_n & (bus.Ctrl ? b_free : a_free);

  assign accept_a  = bus.In_valid & in_ready & ~bus.Ctrl;
  assign accept_b  = bus.In_valid & in_ready &  bus.Ctrl;
  assign deliver_a = (a_state == FULL) & bus.A_ready;
  assign deliver_b = (b_state == FULL) & bus.B_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_state <= EMPTY;
      b_state <= EMPTY;
      a_data  <= '0;
      b_data  <= '0;
      a_cnt   <= 8'd0;
      b_cnt   <= 8'd0;
    end else begin
      // A same-cycle accept takes priority over emptying, so a refilled slot has no bubble.
      case (a_state)
        EMPTY: begin
          if (accept_a) begin
            a_state <= FULL;
            a_data  <= bus.D;
          end
        end
        FULL: begin
          if (accept_a)
            a_data <= bus.D;
          else if (deliver_a)
            a_state <= EMPTY;
        end
        default: a_state <= EMPTY;
      endcase

      case (b_state)
        EMPTY: begin
          if (accept_b) begin
            b_state <= FULL;
            b_data  <= bus.D;
          end
        end
        FULL: begin
          if (accept_b)
            b_data <= bus.D;
          else if (deliver_b)
            b_state <= EMPTY;
        end
        default: b_state <= EMPTY;
      endcase

      if (deliver_a)
        a_cnt <= a_cnt + 8'd1;
      if (deliver_b)
        b_cnt <= b_cnt + 8'd1;
    end
  end

  assign bus.In_ready = in_ready;
  assign bus.A        = a_data;
  assign bus.A_valid  = (a_state == FULL);
  assign bus.B        = b_data;
  assign bus.B_valid  = (b_state == FULL);
  assign bus.A_cnt    = a_cnt;
  assign bus.B_cnt    = b_cnt;

endmodule

// File: tb/tb_clock_demux_2.sv
// Directed self-checking bench for clock_demux_2: reset, routing, back-to-back refill,
// alternating traffic, counter wrap, back-pressure and mid-operation reset.
module tb_clock_demux_2;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   passCount;
  int   failCount;

  clock_demux_2_if #(.N(32)) bus ();

  clock_demux_2 #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Inputs change 1 time unit after a rising edge, so every check sees settled values.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic ctrl, input logic [31:0] d,
                               input logic aReady, input logic bReady);
    bus.In_valid = valid;
    bus.Ctrl     = ctrl;
    bus.D        = d;
    bus.A_ready  = aReady;
    bus.B_ready  = bReady;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    assert (observed === expected)
      passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " A"},       bus.A,             32'h0);
    checkOutput({tag, " B"},       bus.B,             32'h0);
    checkOutput({tag, " A_valid"}, {31'd0, bus.A_valid}, 32'h0);
    checkOutput({tag, " B_valid"}, {31'd0, bus.B_valid}, 32'h0);
    checkOutput({tag, " A_cnt"},   {24'd0, bus.A_cnt},   32'h0);
    checkOutput({tag, " B_cnt"},   {24'd0, bus.B_cnt},   32'h0);
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    checkCount = 0;
    passCount  = 0;
    failCount  = 0;
    rst_n      = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state and forced-low In_ready while rst_n is low.
    checkAllZero("reset");
    checkOutput("reset In_ready", {31'd0, bus.In_ready}, 32'h0);
    rst_n = 1'b1;
    #1;
    checkOutput("release In_ready", {31'd0, bus.In_ready}, 32'h1);

    // First word routed to A; B untouched; readiness depends on selected slot.
    applyStimulus(1'b1, 1'b0, 32'h11111111, 1'b0, 1'b0);
    tick();
    checkOutput("first A",       bus.A,                32'h11111111);
    checkOutput("first A_valid", {31'd0, bus.A_valid}, 32'h1);
    checkOutput("first B_valid", {31'd0, bus.B_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("first In_ready ctrl0", {31'd0, bus.In_ready}, 32'h0);
    applyStimulus(1'b0, 1'b1, 32'h0, 1'b0, 1'b0);
    checkOutput("first In_ready ctrl1", {31'd0, bus.In_ready}, 32'h1);

    // Deliver and refill A in the same cycle: no empty gap.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'hAAAA0000, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 32'hAAAA0001, 1'b1, 1'b0);
    checkOutput("refill In_ready", {31'd0, bus.In_ready}, 32'h1);
    tick();
    checkOutput("refill A",       bus.A,                32'hAAAA0001);
    checkOutput("refill A_valid", {31'd0, bus.A_valid}, 32'h1);
    checkOutput("refill A_cnt",   {24'd0, bus.A_cnt},   32'h1);
    checkOutput("refill B_valid", {31'd0, bus.B_valid}, 32'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("drain A_valid", {31'd0, bus.A_valid}, 32'h0);
    checkOutput("drain A kept",  bus.A,                32'hAAAA0001);
    checkOutput("drain A_cnt",   {24'd0, bus.A_cnt},   32'h2);

    // Alternating destinations with both consumers always ready.
    doReset();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, i[0], 32'hC0000000 + 32'(i), 1'b1, 1'b1);
      checkOutput($sformatf("alt%0d In_ready", i), {31'd0, bus.In_ready}, 32'h1);
      tick();
      if (i[0] == 1'b0)
        checkOutput($sformatf("alt%0d A", i), bus.A, 32'hC0000000 + 32'(i));
      else
        checkOutput($sformatf("alt%0d B", i), bus.B, 32'hC0000000 + 32'(i));
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
    tick();
    checkOutput("alt A_cnt", {24'd0, bus.A_cnt}, 32'd5);
    checkOutput("alt B_cnt", {24'd0, bus.B_cnt}, 32'd5);

    // 256 deliveries on A wrap the counter to zero; one more gives 1.
    doReset();
    for (int i = 0; i < 256; i++) begin
      applyStimulus(1'b1, 1'b0, 32'(i), 1'b1, 1'b0);
      tick();
    end
    checkOutput("wrap pre A_cnt", {24'd0, bus.A_cnt}, 32'd255);
    checkOutput("wrap last A",    bus.A,              32'd255);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("wrap A_cnt",   {24'd0, bus.A_cnt},   32'd0);
    checkOutput("wrap A_valid", {31'd0, bus.A_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 32'h12345678, 1'b1, 1'b0);
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    tick();
    checkOutput("wrap+1 A_cnt", {24'd0, bus.A_cnt}, 32'd1);

    // Back-pressure: full A does not block B; both full blocks everything.
    doReset();
    applyStimulus(1'b1, 1'b0, 32'hA1A1A1A1, 1'b0, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b1, 32'hB1B1B1B1, 1'b0, 1'b0);
    checkOutput("other slot In_ready", {31'd0, bus.In_ready}, 32'h1);
    tick();
    applyStimulus(1'b1, 1'b0, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("full In_ready ctrl0", {31'd0, bus.In_ready}, 32'h0);
    applyStimulus(1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0);
    checkOutput("full In_ready ctrl1", {31'd0, bus.In_ready}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("stall%0d A", i), bus.A, 32'hA1A1A1A1);
      checkOutput($sformatf("stall%0d B", i), bus.B, 32'hB1B1B1B1);
      checkOutput($sformatf("stall%0d valids", i), {30'd0, bus.A_valid, bus.B_valid}, 32'h3);
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    tick();
    checkOutput("release B_cnt",   {24'd0, bus.B_cnt},   32'd1);
    checkOutput("release B_valid", {31'd0, bus.B_valid}, 32'h0);
    checkOutput("release A_valid", {31'd0, bus.A_valid}, 32'h1);
    checkOutput("release A_cnt",   {24'd0, bus.A_cnt},   32'd0);

    // Mid-operation reset with both slots full and a pending handshake.
    applyStimulus(1'b1, 1'b1, 32'hB2B2B2B2, 1'b0, 1'b0);
    tick();
    rst_n = 1'b0;
    applyStimulus(1'b1, 1'b0, 32'h55555555, 1'b1, 1'b1);
    checkOutput("midreset In_ready", {31'd0, bus.In_ready}, 32'h0);
    tick();
    checkAllZero("midreset");
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("post reset In_ready", {31'd0, bus.In_ready}, 32'h1);
    tick();
    checkAllZero("post reset idle");

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
